// File: rtl/rv32i_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_ctrl_pkg
// Shared definitions for the RV32I multi-cycle control unit:
//   - base opcode constants
//   - alu_op_e       : ALU operation select driven on aluControl
//   - rfwd_sel_e     : register-file writeback source select
//   - instr_class_e  : instruction class produced by the decoder
//   - ctrl_state_e   : control FSM states
//   - classify()     : opcode -> instruction class
// ----------------------------------------------------------------------------
package rv32i_ctrl_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111
    } alu_op_e;

    typedef enum logic [2:0] {
        RFWD_ALU   = 3'd0,
        RFWD_LOAD  = 3'd1,
        RFWD_LUI   = 3'd2,
        RFWD_AUIPC = 3'd3,
        RFWD_PC4   = 3'd4
    } rfwd_sel_e;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I,
        CLS_L,
        CLS_S,
        CLS_B,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_ILLEGAL
    } instr_class_e;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_R_EXE,
        ST_I_EXE,
        ST_LUI_EXE,
        ST_AUIPC_EXE,
        ST_B_EXE,
        ST_JAL_EXE,
        ST_JALR_EXE,
        ST_S_EXE,
        ST_S_MEM,
        ST_L_EXE,
        ST_L_MEM,
        ST_L_WB,
        ST_ILLEGAL
    } ctrl_state_e;

    function automatic instr_class_e classify(input logic [6:0] opcode);
        instr_class_e cls;
        case (opcode)
            OP_R:     cls = CLS_R;
            OP_I:     cls = CLS_I;
            OP_L:     cls = CLS_L;
            OP_S:     cls = CLS_S;
            OP_B:     cls = CLS_B;
            OP_JAL:   cls = CLS_JAL;
            OP_JALR:  cls = CLS_JALR;
            OP_LUI:   cls = CLS_LUI;
            OP_AUIPC: cls = CLS_AUIPC;
            default:  cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/rv32i_multicycle_ctrl_decoder.sv
// ----------------------------------------------------------------------------
// rv32i_instr_decoder
// Purely combinational decode of the latched instruction register.
// Ports:
//   i_ir             : latched instruction word
//   o_aluControl     : ALU operation select
//   o_aluSrcMuxSel   : 0 = rs2, 1 = immediate
//   o_RFWDSrcMuxSel  : writeback source select
//   o_instrClass     : instruction class used by the control FSM
// ----------------------------------------------------------------------------
module rv32i_instr_decoder
    import rv32i_ctrl_pkg::*;
(
    input  logic [31:0]  i_ir,
    output logic [3:0]   o_aluControl,
    output logic         o_aluSrcMuxSel,
    output logic [2:0]   o_RFWDSrcMuxSel,
    output instr_class_e o_instrClass
);

    logic [2:0] w_funct3;
    logic       w_funct7b5;
    logic       w_unused_fields;

    assign w_funct3   = i_ir[14:12];
    assign w_funct7b5 = i_ir[30];

    // Register/immediate fields are consumed by the datapath, not by control.
    assign w_unused_fields = ^{i_ir[31], i_ir[29:15], i_ir[11:7]};

    assign o_instrClass = classify(i_ir[6:0]);

    always_comb begin
        o_aluControl    = ALU_ADD;
        o_aluSrcMuxSel  = 1'b0;
        o_RFWDSrcMuxSel = RFWD_ALU;
        case (o_instrClass)
            CLS_R: begin
                o_aluControl = {w_funct7b5, w_funct3};
            end
            CLS_I: begin
                // Only the right shifts use bit 30 to pick SRA over SRL;
                // for every other I-type op that bit belongs to the immediate.
                o_aluControl   = {(w_funct3 == 3'b101) ? w_funct7b5 : 1'b0, w_funct3};
                o_aluSrcMuxSel = 1'b1;
            end
            CLS_L: begin
                o_aluSrcMuxSel  = 1'b1;
                o_RFWDSrcMuxSel = RFWD_LOAD;
            end
            CLS_S: begin
                o_aluSrcMuxSel = 1'b1;
            end
            CLS_B: begin
                // The datapath reads funct3 as a comparator select while branch is high.
                o_aluControl = {1'b0, w_funct3};
            end
            CLS_JAL: begin
                o_RFWDSrcMuxSel = RFWD_PC4;
            end
            CLS_JALR: begin
                o_aluSrcMuxSel  = 1'b1;
                o_RFWDSrcMuxSel = RFWD_PC4;
            end
            CLS_LUI: begin
                o_RFWDSrcMuxSel = RFWD_LUI;
            end
            CLS_AUIPC: begin
                o_RFWDSrcMuxSel = RFWD_AUIPC;
            end
            default: begin
                o_aluControl = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// rv32i_multicycle_ctrl
// Multi-cycle control unit for the RV32I datapath. Latches the instruction in
// FETCH, decodes it, and sequences EXE / MEM / WB states, with a req/ready
// handshake on the data bus so memory can insert wait states.
// Ports:
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_instrCode         : instruction word, sampled in FETCH
//   i_busReady          : data-bus access complete this cycle
//   o_PCEn              : PC load enable, one pulse per retired instruction
//   o_regFileWe         : register file write enable
//   o_aluControl        : ALU op select
//   o_aluSrcMuxSel      : 0 = rs2, 1 = immediate
//   o_RFWDSrcMuxSel     : writeback source select
//   o_branch/o_jal/o_jalr : next-PC source controls
//   o_busReq, o_busWe   : data-bus request and write qualifier
//   o_illegalInstr      : pulse on an unsupported opcode
// ----------------------------------------------------------------------------
module rv32i_multicycle_ctrl
    import rv32i_ctrl_pkg::*;
#(
    parameter bit RESET_PC_EN = 1'b0
)
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_instrCode,
    input  logic        i_busReady,
    output logic        o_PCEn,
    output logic        o_regFileWe,
    output logic [3:0]  o_aluControl,
    output logic        o_aluSrcMuxSel,
    output logic [2:0]  o_RFWDSrcMuxSel,
    output logic        o_branch,
    output logic        o_jal,
    output logic        o_jalr,
    output logic        o_busReq,
    output logic        o_busWe,
    output logic        o_illegalInstr
);

    ctrl_state_e  r_state;
    ctrl_state_e  w_nextState;
    logic [31:0]  r_ir;
    logic         r_firstCycle;

    logic [3:0]   w_decAlu;
    logic         w_decSrc;
    logic [2:0]   w_decRfwd;
    instr_class_e w_class;

    logic         w_pcEn;
    logic         w_regFileWe;

    rv32i_instr_decoder u_decoder (
        .i_ir            (r_ir),
        .o_aluControl    (w_decAlu),
        .o_aluSrcMuxSel  (w_decSrc),
        .o_RFWDSrcMuxSel (w_decRfwd),
        .o_instrClass    (w_class)
    );

    // State, instruction register and the post-reset marker.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_FETCH;
            r_ir         <= '0;
            r_firstCycle <= 1'b1;
        end else begin
            r_state      <= w_nextState;
            r_firstCycle <= 1'b0;
            if (r_state == ST_FETCH) begin
                r_ir <= i_instrCode;
            end
        end
    end

    // Next-state and per-state enables. S_MEM is the only state whose PCEn
    // depends on an input: the store retires in the cycle the bus accepts it.
    always_comb begin
        w_nextState    = r_state;
        w_pcEn         = 1'b0;
        w_regFileWe    = 1'b0;
        o_branch       = 1'b0;
        o_jal          = 1'b0;
        o_jalr         = 1'b0;
        o_busReq       = 1'b0;
        o_busWe        = 1'b0;
        o_illegalInstr = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_nextState = ST_DECODE;
            end
            ST_DECODE: begin
                case (w_class)
                    CLS_R:     w_nextState = ST_R_EXE;
                    CLS_I:     w_nextState = ST_I_EXE;
                    CLS_L:     w_nextState = ST_L_EXE;
                    CLS_S:     w_nextState = ST_S_EXE;
                    CLS_B:     w_nextState = ST_B_EXE;
                    CLS_JAL:   w_nextState = ST_JAL_EXE;
                    CLS_JALR:  w_nextState = ST_JALR_EXE;
                    CLS_LUI:   w_nextState = ST_LUI_EXE;
                    CLS_AUIPC: w_nextState = ST_AUIPC_EXE;
                    default:   w_nextState = ST_ILLEGAL;
                endcase
            end
            ST_R_EXE, ST_I_EXE, ST_LUI_EXE, ST_AUIPC_EXE: begin
                w_regFileWe = 1'b1;
                w_pcEn      = 1'b1;
                w_nextState = ST_FETCH;
            end
            ST_B_EXE: begin
                o_branch    = 1'b1;
                w_pcEn      = 1'b1;
                w_nextState = ST_FETCH;
            end
            ST_JAL_EXE: begin
                o_jal       = 1'b1;
                w_regFileWe = 1'b1;
                w_pcEn      = 1'b1;
                w_nextState = ST_FETCH;
            end
            ST_JALR_EXE: begin
                o_jalr      = 1'b1;
                w_regFileWe = 1'b1;
                w_pcEn      = 1'b1;
                w_nextState = ST_FETCH;
            end
            ST_S_EXE: begin
                w_nextState = ST_S_MEM;
            end
            ST_S_MEM: begin
                o_busReq = 1'b1;
                o_busWe  = 1'b1;
                if (i_busReady) begin
                    w_pcEn      = 1'b1;
                    w_nextState = ST_FETCH;
                end
            end
            ST_L_EXE: begin
                w_nextState = ST_L_MEM;
            end
            ST_L_MEM: begin
                o_busReq = 1'b1;
                if (i_busReady) begin
                    w_nextState = ST_L_WB;
                end
            end
            ST_L_WB: begin
                w_regFileWe = 1'b1;
                w_pcEn      = 1'b1;
                w_nextState = ST_FETCH;
            end
            ST_ILLEGAL: begin
                o_illegalInstr = 1'b1;
                w_pcEn         = 1'b1;
                w_nextState    = ST_FETCH;
            end
            default: begin
                w_nextState = ST_FETCH;
            end
        endcase
    end

    // Architectural commits are suppressed in a reset cycle so an access
    // completing on the reset edge cannot advance the PC or write a register.
    assign o_PCEn      = (w_pcEn | (RESET_PC_EN & r_firstCycle)) & ~i_reset;
    assign o_regFileWe = w_regFileWe & ~i_reset;

    // Decode is meaningless until IR has been captured, so FETCH shows zeros.
    assign o_aluControl    = (r_state == ST_FETCH) ? 4'd0 : w_decAlu;
    assign o_aluSrcMuxSel  = (r_state == ST_FETCH) ? 1'b0 : w_decSrc;
    assign o_RFWDSrcMuxSel = (r_state == ST_FETCH) ? 3'd0 : w_decRfwd;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rv32i_multicycle_ctrl
// Directed instruction sequence against rv32i_multicycle_ctrl. Expected
// per-instruction behaviour is queued when each instruction is issued; a
// monitor accumulates per-cycle activity and compares on every PCEn pulse.
// ----------------------------------------------------------------------------
module tb_rv32i_multicycle_ctrl;

    typedef struct {
        int tag;
        int cycles;
        int req;
        int busWe;
        int rfWe;
        int br;
        int jal;
        int jalr;
        int ill;
        int alu;
        int src;
        int rfwd;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] instrCode;
    logic        busReady;
    logic        PCEn;
    logic        regFileWe;
    logic [3:0]  aluControl;
    logic        aluSrcMuxSel;
    logic [2:0]  RFWDSrcMuxSel;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        busReq;
    logic        busWe;
    logic        illegalInstr;
    logic [15:0] outVec;

    int checks = 0;
    int errors = 0;
    int retireCount = 0;
    exp_t sbQ[$];

    rv32i_multicycle_ctrl dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_instrCode     (instrCode),
        .i_busReady      (busReady),
        .o_PCEn          (PCEn),
        .o_regFileWe     (regFileWe),
        .o_aluControl    (aluControl),
        .o_aluSrcMuxSel  (aluSrcMuxSel),
        .o_RFWDSrcMuxSel (RFWDSrcMuxSel),
        .o_branch        (branch),
        .o_jal           (jal),
        .o_jalr          (jalr),
        .o_busReq        (busReq),
        .o_busWe         (busWe),
        .o_illegalInstr  (illegalInstr)
    );

    assign outVec = {PCEn, regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel,
                     branch, jal, jalr, busReq, busWe, illegalInstr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    function automatic exp_t mk(input int tag, input int cycles, input int req, input int bwe,
                                input int rfWe, input int br, input int j, input int jr,
                                input int ill, input int alu, input int src, input int rfwd);
        exp_t e;
        e.tag = tag; e.cycles = cycles; e.req = req; e.busWe = bwe; e.rfWe = rfWe;
        e.br = br; e.jal = j; e.jalr = jr; e.ill = ill; e.alu = alu; e.src = src; e.rfwd = rfwd;
        return e;
    endfunction

    // Issue one instruction from a FETCH cycle (called at posedge+1). The bus
    // is held not-ready for 'waits' request cycles, then acknowledged.
    task automatic applyStimulus(input logic [31:0] instr, input int waits, input exp_t e);
        int startRetire;
        int waitCnt;
        bit done;
        sbQ.push_back(e);
        startRetire = retireCount;
        waitCnt = 0;
        done = 1'b0;
        instrCode = instr;
        busReady = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
            instrCode = 32'hFFFF_FFFF;
            if (retireCount != startRetire) begin
                done = 1'b1;
            end else if (busReq) begin
                busReady = (waitCnt >= waits);
                waitCnt++;
            end else begin
                busReady = 1'b0;
            end
        end
        if (!done) begin
            checkOutput("retireTimeout", e.tag, -1);
        end
    endtask

    // Start a load, stall it in L_MEM, then reset in the cycle the bus acks.
    task automatic resetDuringLoad();
        int reqSeen;
        reqSeen = 0;
        instrCode = 32'h0040A283;
        busReady = 1'b0;
        for (int i = 0; i < 20 && reqSeen < 2; i++) begin
            @(posedge clk); #1;
            instrCode = 32'hFFFF_FFFF;
            if (busReq) reqSeen++;
        end
        checkOutput("loadReachedMem", reqSeen, 2);
        reset = 1'b1;
        busReady = 1'b1;
        @(posedge clk); #1;
        checkOutput("midWaitResetOutputs", int'(outVec), 0);
        reset = 1'b0;
        busReady = 1'b0;
    endtask

    // Monitor: per-cycle accounting, compared against the queue on each PCEn.
    initial begin
        int cyc, req, bwe, rfWe, br, j, jr, ill;
        exp_t e;
        cyc = 0; req = 0; bwe = 0; rfWe = 0; br = 0; j = 0; jr = 0; ill = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                checkOutput("resetNoCommit", int'({PCEn, regFileWe}), 0);
                cyc = 0; req = 0; bwe = 0; rfWe = 0; br = 0; j = 0; jr = 0; ill = 0;
            end else begin
                cyc++;
                if (cyc == 1) checkOutput("fetchOutputsZero", int'(outVec), 0);
                checkOutput("busWeImpliesReq", int'(busWe & ~busReq), 0);
                req  += int'(busReq);
                bwe  += int'(busWe);
                rfWe += int'(regFileWe);
                br   += int'(branch);
                j    += int'(jal);
                jr   += int'(jalr);
                ill  += int'(illegalInstr);
                if (PCEn) begin
                    if (sbQ.size() == 0) begin
                        checkOutput("unexpectedRetire", 1, 0);
                    end else begin
                        e = sbQ.pop_front();
                        $display("[TB] retire tag=%0d cycles=%0d", e.tag, cyc);
                        checkOutput("cycles",     cyc,  e.cycles);
                        checkOutput("busReqCyc",  req,  e.req);
                        checkOutput("busWeCyc",   bwe,  e.busWe);
                        checkOutput("regWeCyc",   rfWe, e.rfWe);
                        checkOutput("branchCyc",  br,   e.br);
                        checkOutput("jalCyc",     j,    e.jal);
                        checkOutput("jalrCyc",    jr,   e.jalr);
                        checkOutput("illegalCyc", ill,  e.ill);
                        checkOutput("aluControl", int'(aluControl),    e.alu);
                        checkOutput("aluSrc",     int'(aluSrcMuxSel),  e.src);
                        checkOutput("rfwdSel",    int'(RFWDSrcMuxSel), e.rfwd);
                    end
                    retireCount++;
                    cyc = 0; req = 0; bwe = 0; rfWe = 0; br = 0; j = 0; jr = 0; ill = 0;
                end
            end
        end
    end

    // Stimulus: fields are cycles, busReq, busWe, regWe, branch, jal, jalr,
    // illegal cycle counts, then aluControl/aluSrc/rfwd at the retire cycle.
    initial begin
        reset = 1'b1;
        instrCode = 32'h0;
        busReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetOutputs", int'(outVec), 0);
        reset = 1'b0;

        applyStimulus(32'h002081B3, 0, mk(1,  3, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 0)); // add
        applyStimulus(32'h402081B3, 0, mk(2,  3, 0, 0, 1, 0, 0, 0, 0, 4'b1000, 0, 0)); // sub
        applyStimulus(32'h4030D093, 0, mk(3,  3, 0, 0, 1, 0, 0, 0, 0, 4'b1101, 1, 0)); // srai
        applyStimulus(32'hFFF00093, 0, mk(4,  3, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 1, 0)); // addi -1
        applyStimulus(32'h0020A423, 2, mk(5,  6, 3, 3, 0, 0, 0, 0, 0, 4'b0000, 1, 0)); // sw
        applyStimulus(32'h0040A283, 0, mk(6,  5, 1, 0, 1, 0, 0, 0, 0, 4'b0000, 1, 1)); // lw
        applyStimulus(32'h0040A283, 3, mk(7,  8, 4, 0, 1, 0, 0, 0, 0, 4'b0000, 1, 1)); // lw, 3 waits
        applyStimulus(32'h00208463, 0, mk(8,  3, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0)); // beq
        applyStimulus(32'h010000EF, 0, mk(9,  3, 0, 0, 1, 0, 1, 0, 0, 4'b0000, 0, 4)); // jal
        applyStimulus(32'h00209463, 0, mk(10, 3, 0, 0, 0, 1, 0, 0, 0, 4'b0001, 0, 0)); // bne
        applyStimulus(32'h000100E7, 0, mk(11, 3, 0, 0, 1, 0, 0, 1, 0, 4'b0000, 1, 4)); // jalr
        applyStimulus(32'h123452B7, 0, mk(12, 3, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 2)); // lui
        applyStimulus(32'h00001297, 0, mk(13, 3, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 3)); // auipc
        applyStimulus(32'h00000000, 0, mk(14, 3, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 0)); // illegal
        applyStimulus(32'h0020A423, 0, mk(15, 4, 1, 1, 0, 0, 0, 0, 0, 4'b0000, 1, 0)); // sw, no wait

        resetDuringLoad();
        applyStimulus(32'h402081B3, 0, mk(16, 3, 0, 0, 1, 0, 0, 0, 0, 4'b1000, 0, 0)); // sub after reset

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboardEmpty", sbQ.size(), 0);
        checkOutput("retiredCount", retireCount, 16);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_multicycle_ctrl.md
Name: rv32i_multicycle_ctrl

Overview:
Multi-cycle control unit for the RV32I datapath. It latches each instruction and sequences it through fetch, decode, execute, memory and writeback states. It drives the existing datapath control set (PCEn, regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel, branch, jal, jalr) and adds a request/ready handshake on the data bus, so memory and peripherals may insert wait states.

Parameters:
RESET_PC_EN, 0, value of PCEn in the first cycle after reset; kept at 0 for this block.

Ports:
clk            input   1   system clock, rising edge
reset          input   1   synchronous, active-high
instrCode      input   32  instruction word from instruction memory; valid in FETCH
busReady       input   1   data-bus access complete this cycle
PCEn           output  1   PC register load enable; exactly one pulse per retired instruction
regFileWe      output  1   register file write enable
aluControl     output  4   ALU op select (encoding in package)
aluSrcMuxSel   output  1   0 = rs2, 1 = immediate
RFWDSrcMuxSel  output  3   writeback source: 0 ALU, 1 load data, 2 LUI imm, 3 PC+imm, 4 PC+4
branch         output  1   B-type compare/branch active
jal            output  1   JAL target select
jalr           output  1   JALR target select
busReq         output  1   data-bus access request
busWe          output  1   data-bus write (valid only with busReq)
illegalInstr   output  1   one-cycle pulse on an unsupported opcode

Behaviour:
- Reset:
  - Synchronous, active-high.
  - Next edge: state = FETCH, IR = 0, all outputs 0.
  - Reset wins over every other event, including mid-bus-wait. busReq drops on the reset edge; no PCEn is generated.
- IR capture: in FETCH, IR <= instrCode at the clock edge. All decode uses IR, never the live instrCode.
- States: FETCH, DECODE, R_EXE, I_EXE, LUI_EXE, AUIPC_EXE, B_EXE, JAL_EXE, JALR_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB, ILLEGAL.
- Unconditional transitions:
  - FETCH -> DECODE.
  - DECODE -> the *_EXE state selected by opcode: 0110011 R, 0010011 I, 0000011 L, 0100011 S, 1100011 B, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC. Any other opcode -> ILLEGAL.
  - Every single-step EXE state, and ILLEGAL, -> FETCH.
  - S_EXE -> S_MEM.
  - L_EXE -> L_MEM.
- S_MEM:
  - busReq = busWe = 1.
  - Holds while busReady = 0.
  - On busReady = 1: PCEn = 1 in that same cycle, then -> FETCH.
- L_MEM:
  - busReq = 1, busWe = 0.
  - Holds while busReady = 0; on busReady = 1 -> L_WB.
- L_WB: regFileWe = 1, RFWDSrcMuxSel = 1, PCEn = 1, then -> FETCH.
- Enables per state (everything not listed is 0):
  - R_EXE, I_EXE, LUI_EXE, AUIPC_EXE: regFileWe = 1, PCEn = 1.
  - B_EXE: branch = 1, PCEn = 1.
  - JAL_EXE: jal = 1, regFileWe = 1, PCEn = 1.
  - JALR_EXE: jalr = 1, regFileWe = 1, PCEn = 1.
  - ILLEGAL: illegalInstr = 1, PCEn = 1 (instruction skipped, no register write).
- aluControl, aluSrcMuxSel, RFWDSrcMuxSel:
  - Combinational decode of IR, valid from DECODE onward.
  - Forced to 0 in FETCH.
- aluControl encoding:
  - R-type: {funct7[5], funct3}.
  - I-type: {funct3==101 ? funct7[5] : 0, funct3}.
  - Load, store, JALR: ADD.
  - B-type: {0, funct3}; the datapath reads this as a comparator select when branch = 1.
- aluSrcMuxSel: 1 for I, load, store, JALR; 0 otherwise.
- Cycle counts per instruction, FETCH to PCEn inclusive:
  - ALU, LUI, AUIPC, B, J: 3.
  - Store: 4 + wait cycles.
  - Load: 5 + wait cycles.
  - Illegal: 3.
- busReady outside S_MEM or L_MEM is ignored.
- busWe is never 1 while busReq = 0.

Decomposition:
- Package rv32i_ctrl_pkg holds:
  - opcode localparams;
  - alu_op_e enum (ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111);
  - rfwd_sel_e enum (0–4 as above);
  - ctrl_state_e enum.
- One sub-module, rv32i_instr_decoder: purely combinational, IR -> aluControl, aluSrcMuxSel, RFWDSrcMuxSel, instruction class.
- The FSM lives in the top module.

Test Plan:
- add x3,x1,x2 (0x002081B3):
  - DECODE->R_EXE with aluControl = 0000, aluSrcMuxSel = 0, RFWDSrcMuxSel = 0.
  - regFileWe = PCEn = 1 in cycle 3 only.
  - sub (0x402081B3): aluControl = 1000.
- sw x2,8(x1) (0x0020A423) with busReady held low 2 cycles:
  - busReq = busWe = 1 for 3 cycles.
  - PCEn pulses in the busReady cycle; total 6 cycles; regFileWe stays 0.
- lw x5,4(x1) (0x0040A283) with busReady = 1 immediately:
  - L_MEM lasts 1 cycle.
  - L_WB asserts regFileWe = 1, RFWDSrcMuxSel = 1, PCEn = 1; total 5 cycles.
- beq (0x00208463), then jal x1,16 (0x010000EF):
  - branch = 1 only in beq's cycle 3.
  - jal = 1, regFileWe = 1, RFWDSrcMuxSel = 4 in jal's cycle 3.
  - Exactly one PCEn per instruction.
- Instruction 0x00000000: ILLEGAL state; illegalInstr = PCEn = 1 for one cycle; regFileWe, busReq = 0.
- Reset asserted during an L_MEM wait: next edge all outputs 0 and state FETCH, with no PCEn or regFileWe. After release, the next instruction is fetched from IR = instrCode.
